blink_detector: RTL and testbench

BLINK_DETECTOR -- requirements
Module: blink_detector

---
 rtl/blink_pkg.sv | 15 +
 rtl/sync_edge.sv | 36 +++
 rtl/blink_detector.sv | 156 +++++++++++++++
 tb/tb_blink_detector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the blink detector: FSM encoding and default parameters.
package blink_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned TOL_DEF     = 4;
  localparam int unsigned LOCK_N_DEF  = 4;
  localparam int unsigned EDGE_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a registered toggle detector
// that flags the cycle in which the synchronized level differs from its previous value.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic edge_evt
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic evt_q, evt_d;

  always_comb begin
    s1_d  = async_in;
    s2_d  = s1_q;
    evt_d = s1_q ^ s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      evt_q <= evt_d;
    end
  end

  assign level    = s2_q;
  assign edge_evt = evt_q;

endmodule

// File: rtl/blink_detector.sv
// Measures the half-period of an asynchronous blink waveform and locks when
// LOCK_N consecutive half-periods fall within TOL clocks of the expected value.
module blink_detector
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned TOL    = TOL_DEF,
  parameter int unsigned LOCK_N = LOCK_N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  blink_in,
  input  logic [CNT_W-1:0]      expected_half,
  output logic [CNT_W-1:0]      half_period,
  output logic                  period_valid,
  output logic                  locked,
  output logic                  lost,
  output logic [EDGE_CNT_W-1:0] edge_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic edge_evt;
  logic blink_level_unused;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (blink_in),
    .level    (blink_level_unused),
    .edge_evt (edge_evt)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]        half_period_q, half_period_d;
  logic [MATCH_W-1:0]      match_q, match_d;
  logic                    period_valid_q, period_valid_d;
  logic                    locked_q, locked_d;
  logic                    lost_q, lost_d;
  logic [EDGE_CNT_W-1:0]   edge_count_q, edge_count_d;

  logic                    run_sat;
  logic [CNT_W-1:0]        meas;
  logic [CNT_W:0]          meas_x, exp_x, abs_diff, timeout_thr;
  logic                    is_match, timeout;
  logic [MATCH_W-1:0]      match_inc;

  // Measurement, tolerance window and timeout threshold, all without wrap
  always_comb begin
    run_sat     = (run_cnt_q == CNT_MAX);
    meas        = run_sat ? run_cnt_q : run_cnt_q + 1'b1;
    meas_x      = {1'b0, meas};
    exp_x       = {1'b0, expected_half};
    abs_diff    = (meas_x >= exp_x) ? (meas_x - exp_x) : (exp_x - meas_x);
    is_match    = (abs_diff <= (CNT_W + 1)'(TOL));
    timeout_thr = exp_x + (CNT_W + 1)'(TOL + 1);
    timeout     = ({1'b0, run_cnt_q} >= timeout_thr);
    match_inc   = match_q + MATCH_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    run_cnt_d      = edge_evt ? '0 : (run_sat ? run_cnt_q : run_cnt_q + 1'b1);
    half_period_d  = half_period_q;
    match_d        = match_q;
    period_valid_d = 1'b0;
    lost_d         = 1'b0;
    edge_count_d   = edge_count_q;

    if (!ena) begin
      state_d      = ST_IDLE;
      run_cnt_d    = '0;
      match_d      = '0;
      edge_count_d = '0;
    end else begin
      if (edge_evt) edge_count_d = edge_count_q + EDGE_CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          // First edge is only a reference; nothing is measured yet
          if (edge_evt) begin
            state_d = ST_MEASURE;
            match_d = '0;
          end
        end
        ST_MEASURE: begin
          if (edge_evt) begin
            half_period_d  = meas;
            period_valid_d = 1'b1;
            if (is_match) begin
              if (32'(match_inc) >= LOCK_N) begin
                state_d = ST_LOCKED;
                match_d = '0;
              end else begin
                match_d = match_inc;
              end
            end else begin
              match_d = '0;
            end
          end else if (run_sat) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // An edge takes priority over a timeout reached in the same cycle
          if (edge_evt) begin
            half_period_d  = meas;
            period_valid_d = 1'b1;
            if (!is_match) begin
              state_d = ST_MEASURE;
              match_d = '0;
              lost_d  = 1'b1;
            end
          end else if (timeout) begin
            state_d = ST_IDLE;
            lost_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      run_cnt_q      <= '0;
      half_period_q  <= '0;
      match_q        <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      run_cnt_q      <= run_cnt_d;
      half_period_q  <= half_period_d;
      match_q        <= match_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
      edge_count_q   <= edge_count_d;
    end
  end

  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign lost         = lost_q;
  assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_blink_detector.sv
// Bench for blink_detector: directed scenarios plus randomized half-periods,
// every cycle compared against a timestamp-based reference model.
module tb_blink_detector;

  localparam int TOL    = 4;
  localparam int LOCK_N = 4;
  localparam int MAXV   = 65535;
  localparam int S_IDLE = 0;
  localparam int S_MEAS = 1;
  localparam int S_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        blink_in;
  logic [15:0] expected_half;
  logic [15:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        lost;
  logic [7:0]  edge_count;

  always #5 clk = ~clk;

  blink_detector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .blink_in      (blink_in),
    .expected_half (expected_half),
    .half_period   (half_period),
    .period_valid  (period_valid),
    .locked        (locked),
    .lost          (lost),
    .edge_count    (edge_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: n = clock edge index, r = edge index of last counter clear
  int m_n, m_r, m_st, m_match, m_ecnt, m_hp;
  bit m_pv, m_lost;
  bit h1, h2, h3;
  bit lost_seen, pv_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_r = 0; m_st = S_IDLE; m_match = 0; m_ecnt = 0; m_hp = 0;
    m_pv = 0; m_lost = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_step();
    bit ev;
    int run, meas, dif;
    bit ok;
    m_n++;
    // synchronized level is two samples old; toggle seen one clock later
    ev = (h2 != h3);
    h3 = h2; h2 = h1; h1 = blink_in;
    run = m_n - 1 - m_r;
    if (run > MAXV) run = MAXV;
    m_pv = 0; m_lost = 0;
    if (!ena) begin
      m_st = S_IDLE; m_r = m_n; m_match = 0; m_ecnt = 0;
    end else if (ev) begin
      m_r = m_n;
      m_ecnt = (m_ecnt + 1) % 256;
      meas = (run + 1 > MAXV) ? MAXV : run + 1;
      dif = meas - int'(expected_half);
      if (dif < 0) dif = -dif;
      ok = (dif <= TOL);
      if (m_st == S_IDLE) begin
        m_st = S_MEAS; m_match = 0;
      end else begin
        m_hp = meas; m_pv = 1;
        if (m_st == S_MEAS) begin
          if (ok) begin
            m_match++;
            if (m_match >= LOCK_N) begin m_st = S_LOCK; m_match = 0; end
          end else m_match = 0;
        end else if (!ok) begin
          m_st = S_MEAS; m_match = 0; m_lost = 1;
        end
      end
    end else begin
      if (m_st == S_LOCK && run >= int'(expected_half) + TOL + 1) begin
        m_st = S_IDLE; m_lost = 1;
      end else if (m_st == S_MEAS && run == MAXV) begin
        m_st = S_IDLE;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    if (rst_n) begin
      chk("half_period", 32'(half_period), 32'(m_hp));
      chk("period_valid", 32'(period_valid), 32'(m_pv));
      chk("locked", 32'(locked), 32'(m_st == S_LOCK));
      chk("lost", 32'(lost), 32'(m_lost));
      chk("edge_count", 32'(edge_count), 32'(m_ecnt));
    end
    if (lost) lost_seen = 1;
    if (period_valid) pv_seen = 1;
  endtask

  task automatic half(input int len);
    blink_in = ~blink_in;
    repeat (len) tick();
  endtask

  initial begin
    logic [15:0] cnt;
    bit seen4, seen5;
    int len, e;

    rst_n = 0; ena = 0; blink_in = 0; expected_half = 16'd256;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    ena = 1;
    repeat (3) half(30);

    // asynchronous reset mid-clock
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_hp", 32'(half_period), 0);
    chk("rst_pv", 32'(period_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_lost", 32'(lost), 0);
    chk("rst_ecnt", 32'(edge_count), 0);
    blink_in = 0;
    repeat (2) tick();
    rst_n = 1;
    pv_seen = 0;
    half(40);
    chk("rst_ref_no_pv", 32'(pv_seen), 0);
    chk("rst_ref_ecnt", 32'(edge_count), 1);

    // free-running counter, bit 8
    blink_in = 0; ena = 0;
    repeat (5) tick();
    ena = 1; cnt = '0; seen4 = 0; seen5 = 0;
    for (int i = 0; i < 1700; i++) begin
      blink_in = cnt[8];
      tick();
      cnt = cnt + 16'd1;
      if (period_valid) chk("cnt_hp256", 32'(half_period), 256);
      if (edge_count == 8'd4 && !seen4) begin seen4 = 1; chk("cnt_unlocked_e4", 32'(locked), 0); end
      if (edge_count == 8'd5 && !seen5) begin seen5 = 1; chk("cnt_locked_e5", 32'(locked), 1); end
    end
    chk("cnt_locked", 32'(locked), 1);

    // one-cycle enable drop while locked
    ena = 0;
    tick();
    ena = 1;
    chk("ena_locked", 32'(locked), 0);
    chk("ena_ecnt", 32'(edge_count), 0);
    chk("ena_hp", 32'(half_period), 256);

    // jitter 252/260 locks; a single 261 loses lock
    for (int i = 0; i < 10; i++) half((i % 2) ? 260 : 252);
    chk("jit_locked", 32'(locked), 1);
    lost_seen = 0;
    half(261);
    half(252);
    chk("jit_lost", 32'(lost_seen), 1);
    chk("jit_unlocked", 32'(locked), 0);
    chk("jit_hp", 32'(half_period), 261);

    // relock, then stuck input times out
    for (int i = 0; i < 6; i++) half(256);
    chk("relock", 32'(locked), 1);
    lost_seen = 0;
    half(400);
    chk("stuck_lost", 32'(lost_seen), 1);
    chk("stuck_unlocked", 32'(locked), 0);
    chk("stuck_ecnt", 32'(edge_count), 19);

    // randomized half-periods, expected values and enable drops
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) expected_half = 16'($urandom_range(16, 48));
      e = int'(expected_half);
      if ($urandom_range(0, 9) == 0) len = e + TOL + 1 + int'($urandom_range(0, 3));
      else len = e + int'($urandom_range(0, 12)) - 6;
      blink_in = ~blink_in;
      for (int j = 0; j < len; j++) begin
        ena = ($urandom_range(0, 63) != 0);
        tick();
      end
      ena = 1;
    end

    // quiet input in MEASURE saturates the counter and returns to IDLE
    expected_half = 16'd256;
    ena = 0;
    tick();
    ena = 1;
    lost_seen = 0;
    half(66000);
    chk("quiet_no_lost", 32'(lost_seen), 0);
    pv_seen = 0;
    half(20);
    chk("quiet_no_pv", 32'(pv_seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
